// File: rtl/opb_ts_snapshot_ctrl.sv
// opb_ts_snapshot_ctrl: arms on a CTRL write, latches each channel's timestamp on
// its first valid strobe, then freezes the set for OPB readback.
module opb_ts_snapshot_ctrl #(
    parameter logic [31:0] C_BASEADDR   = 32'h0108B700,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108B7FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned C_TIMEOUT    = 1024
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [32*N_CH-1:0]        ts_in,
    input  logic [N_CH-1:0]           ts_valid,
    output logic                      snap_busy
);

    localparam int unsigned AW    = C_OPB_AWIDTH;
    localparam int unsigned DW    = C_OPB_DWIDTH;
    localparam int unsigned IDX_W = AW - 2;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMR_W = 16;

    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(C_TIMEOUT - 1);
    localparam logic [N_CH-1:0]  MASK_FULL  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t             state;
    logic [N_CH-1:0]    mask;
    logic               timeout;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   snap_count;
    logic [31:0]        snap [N_CH];

    logic [AW-1:0]      abus;
    logic [DW-1:0]      wdata;
    logic [AW-1:0]      offset;
    logic [IDX_W-1:0]   word_idx;
    logic               hit;
    logic               sel_hold;
    logic               wr_arm;
    logic               wr_clear;
    logic [DW-1:0]      dbus_q;
    logic [31:0]        status_word;
    logic [31:0]        rd_word;
    logic [N_CH-1:0]    cap;
    logic [N_CH-1:0]    mask_nxt;
    logic               unused_bits;

    // Bus-order vectors mapped MSB-first onto conventional descending vectors
    assign abus     = OPB_ABus;
    assign wdata    = OPB_DBus;
    assign offset   = abus - AW'(C_BASEADDR);
    assign word_idx = offset[AW-1:2];
    assign hit      = OPB_select && (abus >= AW'(C_BASEADDR)) && (abus <= AW'(C_HIGHADDR));

    assign Sl_DBus    = dbus_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign unused_bits = ^{OPB_BE, OPB_seqAddr, wdata[DW-3:0], offset[1:0]};

    // Channels that latch this cycle if armed, and the resulting mask
    assign cap      = ts_valid & ~mask;
    assign mask_nxt = mask | cap;

    // STATUS word: state, timeout, entry count, captured mask (channel 0 in LSB)
    always_comb begin
        status_word          = '0;
        status_word[31:30]   = state;
        status_word[29]      = timeout;
        status_word[23:8]    = snap_count;
        status_word[N_CH-1:0] = mask;
    end

    // Read mux; CTRL and unmapped offsets read as zero
    always_comb begin
        rd_word = '0;
        if (word_idx == IDX_W'(1)) begin
            rd_word = status_word;
        end
        for (int k = 0; k < N_CH; k++) begin
            if (word_idx == IDX_W'(k + 2)) begin
                rd_word = snap[k];
            end
        end
    end

    // OPB slave: one ack per select, read data and CTRL pulses registered into the ack cycle
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            sel_hold   <= 1'b1;
            Sl_xferAck <= 1'b0;
            dbus_q     <= '0;
            wr_arm     <= 1'b0;
            wr_clear   <= 1'b0;
        end else begin
            Sl_xferAck <= 1'b0;
            dbus_q     <= '0;
            wr_arm     <= 1'b0;
            wr_clear   <= 1'b0;
            if (!OPB_select) begin
                sel_hold <= 1'b0;
            end else if (hit && !sel_hold) begin
                sel_hold   <= 1'b1;
                Sl_xferAck <= 1'b1;
                if (OPB_RNW) begin
                    dbus_q <= DW'(rd_word);
                end else if (word_idx == '0) begin
                    wr_arm   <= wdata[DW-1];
                    wr_clear <= wdata[DW-2];
                end
            end
        end
    end

    // Capture FSM with timer, mask, snapshot registers and entry counter
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            state      <= S_IDLE;
            snap_busy  <= 1'b0;
            mask       <= '0;
            timeout    <= 1'b0;
            timer      <= '0;
            snap_count <= '0;
            for (int k = 0; k < N_CH; k++) begin
                snap[k] <= '0;
            end
        end else if (wr_arm) begin
            state     <= S_ARMED;
            snap_busy <= 1'b1;
            mask      <= '0;
            timeout   <= 1'b0;
            timer     <= '0;
            for (int k = 0; k < N_CH; k++) begin
                snap[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    snap_busy <= 1'b0;
                end
                S_ARMED: begin
                    if (wr_clear) begin
                        state     <= S_IDLE;
                        snap_busy <= 1'b0;
                    end else if (mask == MASK_FULL) begin
                        state      <= S_READY;
                        snap_busy  <= 1'b0;
                        snap_count <= snap_count + CNT_W'(1);
                    end else begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (cap[k]) begin
                                snap[k] <= ts_in[32*k +: 32];
                            end
                        end
                        mask <= mask_nxt;
                        if (timer == TIMER_LAST) begin
                            state      <= S_READY;
                            snap_busy  <= 1'b0;
                            timeout    <= (mask_nxt != MASK_FULL);
                            snap_count <= snap_count + CNT_W'(1);
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end
                S_READY: begin
                    if (wr_clear) begin
                        state     <= S_IDLE;
                        snap_busy <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    snap_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opb_ts_snapshot_ctrl.sv
// Directed bench for opb_ts_snapshot_ctrl: bus accesses with hand-computed expectations.
module tb_opb_ts_snapshot_ctrl;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned C_TIMEOUT = 1024;
    localparam logic [31:0] BASE      = 32'h0108B700;
    localparam logic [31:0] HIGH      = 32'h0108B7FF;
    localparam logic [31:0] A_CTRL    = BASE;
    localparam logic [31:0] A_STATUS  = BASE + 32'h4;
    localparam logic [31:0] ARM       = 32'h8000_0000;
    localparam logic [31:0] CLEAR     = 32'h4000_0000;

    logic              clk;
    logic              rst_n;
    logic [0:31]       abus;
    logic [0:3]        be;
    logic [0:31]       dbus_w;
    logic              rnw;
    logic              sel;
    logic              seq;
    logic [0:31]       sl_dbus;
    logic              ack;
    logic              err_ack;
    logic              retry;
    logic              tout_sup;
    logic [32*N_CH-1:0] ts_in;
    logic [N_CH-1:0]   ts_valid;
    logic              busy;

    int n_checks;
    int n_errors;

    opb_ts_snapshot_ctrl #(
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (HIGH),
        .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32),
        .N_CH        (N_CH),
        .C_TIMEOUT   (C_TIMEOUT)
    ) dut (
        .OPB_Clk    (clk),
        .OPB_Rst    (rst_n),
        .OPB_ABus   (abus),
        .OPB_BE     (be),
        .OPB_DBus   (dbus_w),
        .OPB_RNW    (rnw),
        .OPB_select (sel),
        .OPB_seqAddr(seq),
        .Sl_DBus    (sl_dbus),
        .Sl_xferAck (ack),
        .Sl_errAck  (err_ack),
        .Sl_retry   (retry),
        .Sl_toutSup (tout_sup),
        .ts_in      (ts_in),
        .ts_valid   (ts_valid),
        .snap_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] a_snap(input int k);
        return BASE + 32'(8 + 4 * k);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Read one word; returns DEADDEAD if no ack arrives within the budget
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        logic acked;
        acked = 1'b0;
        data  = 32'hDEAD_DEAD;
        sel   = 1'b1;
        rnw   = 1'b1;
        abus  = addr;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1;
                data  = sl_dbus;
            end
        end
        sel  = 1'b0;
        rnw  = 1'b0;
        abus = '0;
        check("read_ack", 32'(acked), 32'd1);
        @(negedge clk);
    endtask

    // Write one word; vld is driven on ts_valid during the ack cycle
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [N_CH-1:0] vld);
        logic acked;
        acked  = 1'b0;
        sel    = 1'b1;
        rnw    = 1'b0;
        abus   = addr;
        dbus_w = data;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (ack) acked = 1'b1;
        end
        sel      = 1'b0;
        abus     = '0;
        ts_valid = vld;
        check("write_ack", 32'(acked), 32'd1);
        @(negedge clk);
        ts_valid = '0;
        dbus_w   = '0;
    endtask

    logic [31:0] rd;
    int          cnt;
    int          nz;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        abus     = A_STATUS;
        be       = 4'hF;
        dbus_w   = '0;
        rnw      = 1'b1;
        sel      = 1'b1;
        seq      = 1'b0;
        ts_in    = '0;
        ts_valid = '0;

        // Reset with select held high: nothing acked, outputs quiet
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dbus", sl_dbus, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) cnt++;
        end
        check("abort_no_ack", 32'(cnt), 32'd0);
        sel = 1'b0;
        @(negedge clk);
        bus_read(A_STATUS, rd);
        check("status_reset", rd, 32'h0000_0000);

        // Full capture, one channel per cycle
        ts_in[31:0]   = 32'h1111_1111;
        ts_in[63:32]  = 32'h2222_2222;
        ts_in[95:64]  = 32'h3333_3333;
        ts_in[127:96] = 32'h4444_4444;
        bus_write(A_CTRL, ARM, '0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) cnt++;
            ts_valid = (i < 4) ? 4'(1 << i) : 4'b0000;
            @(negedge clk);
        end
        check("busy_cycles", 32'(cnt), 32'd5);
        bus_read(A_STATUS, rd);
        check("status_ready", rd, 32'h8000_010F);
        bus_read(a_snap(0), rd); check("snap0", rd, 32'h1111_1111);
        bus_read(a_snap(1), rd); check("snap1", rd, 32'h2222_2222);
        bus_read(a_snap(2), rd); check("snap2", rd, 32'h3333_3333);
        bus_read(a_snap(3), rd); check("snap3", rd, 32'h4444_4444);

        // Timeout with channels 0 and 2 only (latched in the same cycle)
        ts_in[31:0]   = 32'hA0A0_A0A0;
        ts_in[63:32]  = 32'hB1B1_B1B1;
        ts_in[95:64]  = 32'hC2C2_C2C2;
        ts_in[127:96] = 32'hD3D3_D3D3;
        bus_write(A_CTRL, ARM, '0);
        check("to_busy_start", 32'(busy), 32'd1);
        ts_valid = 4'b0101;
        @(negedge clk);
        ts_valid = '0;
        repeat (C_TIMEOUT - 2) @(negedge clk);
        check("to_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("to_busy_done", 32'(busy), 32'd0);
        bus_read(A_STATUS, rd);
        check("status_timeout", rd, 32'hA000_0205);
        bus_read(a_snap(0), rd); check("to_snap0", rd, 32'hA0A0_A0A0);
        bus_read(a_snap(1), rd); check("to_snap1", rd, 32'h0000_0000);
        bus_read(a_snap(2), rd); check("to_snap2", rd, 32'hC2C2_C2C2);
        bus_read(a_snap(3), rd); check("to_snap3", rd, 32'h0000_0000);

        // ARM write beats a same-cycle strobe; first later strobe wins
        ts_in[31:0] = 32'h1234_5678;
        bus_write(A_CTRL, ARM, 4'b0001);
        bus_read(A_STATUS, rd);
        check("status_armed", rd, 32'h4000_0200);
        ts_in[31:0] = 32'h9ABC_DEF0;
        ts_valid    = 4'b0001;
        @(negedge clk);
        ts_in[31:0] = 32'h5555_5555;
        @(negedge clk);
        ts_valid = '0;
        bus_read(a_snap(0), rd);
        check("no_overwrite", rd, 32'h9ABC_DEF0);
        bus_read(A_STATUS, rd);
        check("status_mask1", rd, 32'h4000_0201);
        ts_valid = 4'b1110;
        @(negedge clk);
        ts_valid = '0;
        @(negedge clk);
        bus_read(A_STATUS, rd);
        check("status_ready2", rd, 32'h8000_030F);
        bus_read(a_snap(1), rd);
        check("snap1_b", rd, 32'hB1B1_B1B1);

        // READY ignores strobes; CLEAR returns to IDLE keeping snapshots
        for (int k = 0; k < N_CH; k++) ts_in[32*k +: 32] = 32'hFFFF_0000 + 32'(k);
        ts_valid = 4'b1111;
        repeat (2) @(negedge clk);
        ts_valid = '0;
        bus_read(a_snap(0), rd); check("frozen0", rd, 32'h9ABC_DEF0);
        bus_read(a_snap(3), rd); check("frozen3", rd, 32'hD3D3_D3D3);
        bus_read(A_STATUS, rd);  check("status_frozen", rd, 32'h8000_030F);
        bus_write(A_CTRL, CLEAR, '0);
        check("clear_busy", 32'(busy), 32'd0);
        bus_read(A_STATUS, rd);
        check("clear_hi", rd & 32'hFFFF_FF00, 32'h0000_0300);
        bus_read(a_snap(2), rd);
        check("clear_keep2", rd, 32'hC2C2_C2C2);

        // ARM+CLEAR together arms; CLEAR in ARMED goes idle without a READY entry
        bus_write(A_CTRL, ARM | CLEAR, '0);
        bus_read(A_STATUS, rd);
        check("armclr_armed", rd & 32'hFFFF_FF00, 32'h4000_0300);
        bus_write(A_CTRL, CLEAR, '0);
        bus_read(A_STATUS, rd);
        check("armed_clear", rd & 32'hFFFF_FF00, 32'h0000_0300);

        // Re-arm and fill so SNAP0 holds a known value for the hold test
        ts_in[31:0] = 32'h0BAD_F00D;
        bus_write(A_CTRL, ARM, '0);
        ts_valid = 4'b1111;
        @(negedge clk);
        ts_valid = '0;
        @(negedge clk);

        // Select held four cycles: exactly one ack, data zero outside it
        sel  = 1'b1;
        rnw  = 1'b1;
        abus = a_snap(0);
        cnt  = 0;
        nz   = 0;
        rd   = 32'hDEAD_DEAD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin
                cnt++;
                rd = sl_dbus;
            end else if (sl_dbus != 32'd0) begin
                nz++;
            end
        end
        sel = 1'b0;
        @(negedge clk);
        if (ack) cnt++;
        check("hold_one_ack", 32'(cnt), 32'd1);
        check("hold_data", rd, 32'h0BAD_F00D);
        check("dbus_idle_zero", 32'(nz), 32'd0);

        // Unmapped offset acked with zero; out-of-window never acked
        bus_read(BASE + 32'h40, rd);
        check("unmapped_rd", rd, 32'h0000_0000);
        bus_write(BASE + 32'h40, 32'hFFFF_FFFF, '0);
        sel  = 1'b1;
        rnw  = 1'b1;
        abus = HIGH + 32'h1;
        cnt  = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) cnt++;
        end
        sel = 1'b0;
        @(negedge clk);
        check("outside_no_ack", 32'(cnt), 32'd0);
        bus_read(A_STATUS, rd);
        check("status_final", rd, 32'h8000_040F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
